// File: rtl/vadd_sched_if.sv
// Host/adder-pool handshake bundle for vadd_sched.
// slave = scheduler side, master = host + adder pool side.
interface vadd_sched_if #(
    parameter int NUM_ADDERS = 4,
    parameter int LEN_W      = 16
);
    logic                  start;
    logic [LEN_W-1:0]      len;
    logic                  busy;
    logic                  done;
    logic                  issue_valid;
    logic                  issue_ready;
    logic [LEN_W-1:0]      issue_offset;
    logic [NUM_ADDERS-1:0] issue_mask;
    logic                  cmpl_valid;
    logic                  err;
    logic [31:0]           perf_stall;

    modport master (
        output start, len, issue_ready, cmpl_valid,
        input  busy, done, issue_valid, issue_offset, issue_mask, err, perf_stall
    );

    modport slave (
        input  start, len, issue_ready, cmpl_valid,
        output busy, done, issue_valid, issue_offset, issue_mask, err, perf_stall
    );
endinterface

// File: rtl/vadd_sched.sv
// Chunk scheduler for a vector add over NUM_ADDERS lanes with credit-bounded issue.
// Optional stall counter enabled by defining VADD_SCHED_PERF_EN.
module vadd_sched #(
    parameter int NUM_ADDERS   = 4,
    parameter int LEN_W        = 16,
    parameter int MAX_INFLIGHT = 2
) (
    input logic         clk,
    input logic         rst_n,
    vadd_sched_if.slave sched
);
    localparam int OW  = LEN_W + 1;
    localparam int IFW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [OW-1:0]  STEP = OW'(NUM_ADDERS);
    localparam logic [IFW-1:0] CRED = IFW'(MAX_INFLIGHT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [OW-1:0]         off_q, off_d;
    logic [IFW-1:0]        inflight_q, inflight_d;
    logic                  err_q, err_d;
    logic                  valid_q, valid_d;
    logic [NUM_ADDERS-1:0] mask_q, mask_d;
    logic                  done_q, busy_q;
    logic                  hs, start_acc;
    logic [OW-1:0]         rem;

    always_comb begin
        hs         = valid_q && sched.issue_ready;
        start_acc  = (state_q == S_IDLE) && sched.start;
        state_d    = state_q;
        len_d      = len_q;
        off_d      = off_q;
        err_d      = err_q;
        inflight_d = inflight_q;

        // Issue and retire on the same edge cancel out.
        if (hs && !sched.cmpl_valid) begin
            inflight_d = inflight_q + IFW'(1);
        end else if (!hs && sched.cmpl_valid) begin
            if (inflight_q == '0) err_d = 1'b1;
            else                  inflight_d = inflight_q - IFW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (sched.start) begin
                    err_d = 1'b0;
                    if (sched.len != '0) begin
                        len_d   = sched.len;
                        off_d   = '0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (hs) begin
                    off_d = off_q + STEP;
                    if (off_q + STEP >= {1'b0, len_q}) state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (inflight_q == '0) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are precomputed from next state so they can be registered.
        valid_d = (state_d == S_ISSUE) && (inflight_d < CRED);
        rem     = {1'b0, len_d} - off_d;
        mask_d  = '0;
        for (int i = 0; i < NUM_ADDERS; i++) begin
            mask_d[i] = valid_d && (OW'(i) < rem);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            off_q      <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            mask_q     <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            off_q      <= off_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            mask_q     <= mask_d;
            done_q     <= (state_d == S_DONE);
            busy_q     <= (state_d != S_IDLE);
        end
    end

`ifdef VADD_SCHED_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (start_acc) begin
            perf_q <= '0;
        end else if (valid_q && !sched.issue_ready && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign sched.perf_stall = perf_q;
`else
    assign sched.perf_stall = '0;
`endif

    assign sched.busy         = busy_q;
    assign sched.done         = done_q;
    assign sched.issue_valid  = valid_q;
    assign sched.issue_offset = off_q[LEN_W-1:0];
    assign sched.issue_mask   = mask_q;
    assign sched.err          = err_q;
endmodule

// File: tb/tb_vadd_sched.sv
// Directed bench for vadd_sched: exact multiple, tail, credits, backpressure,
// zero length / spurious completion, reset mid-job.
module tb_vadd_sched;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

`ifdef VADD_SCHED_PERF_EN
    localparam logic [31:0] PERF_EXP = 32'd3;
`else
    localparam logic [31:0] PERF_EXP = 32'd0;
`endif

    vadd_sched_if #(.NUM_ADDERS(4), .LEN_W(16)) bus ();

    vadd_sched #(.NUM_ADDERS(4), .LEN_W(16), .MAX_INFLIGHT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sched (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"},  32'(bus.busy),         32'd0);
        chk({tag, "_done"},  32'(bus.done),         32'd0);
        chk({tag, "_valid"}, 32'(bus.issue_valid),  32'd0);
        chk({tag, "_off"},   32'(bus.issue_offset), 32'd0);
        chk({tag, "_mask"},  32'(bus.issue_mask),   32'd0);
        chk({tag, "_err"},   32'(bus.err),          32'd0);
        chk({tag, "_perf"},  bus.perf_stall,        32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.len = '0;
        bus.issue_ready = 1'b1;
        bus.cmpl_valid = 1'b0;
        #3;
        chk_reset_outs("rst");
        #9 rst_n = 1'b1;
        tick();

        // Exact multiple, len=8
        bus.start = 1'b1; bus.len = 16'd8;
        tick();
        bus.start = 1'b0;
        chk("t1_valid0", 32'(bus.issue_valid), 32'd1);
        chk("t1_off0", 32'(bus.issue_offset), 32'd0);
        chk("t1_mask0", 32'(bus.issue_mask), 32'hF);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("t1_off1", 32'(bus.issue_offset), 32'd4);
        chk("t1_mask1", 32'(bus.issue_mask), 32'hF);
        tick();
        chk("t1_drain_valid", 32'(bus.issue_valid), 32'd0);
        chk("t1_drain_mask", 32'(bus.issue_mask), 32'd0);
        bus.cmpl_valid = 1'b1;
        tick();
        tick();
        bus.cmpl_valid = 1'b0;
        chk("t1_done_early", 32'(bus.done), 32'd0);
        tick();
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_done_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("t1_done_end", 32'(bus.done), 32'd0);
        chk("t1_idle_busy", 32'(bus.busy), 32'd0);
        chk("t1_err", 32'(bus.err), 32'd0);

        // Tail, len=10
        bus.start = 1'b1; bus.len = 16'd10;
        tick();
        bus.start = 1'b0;
        chk("t2_off0", 32'(bus.issue_offset), 32'd0);
        chk("t2_mask0", 32'(bus.issue_mask), 32'hF);
        tick();
        chk("t2_off1", 32'(bus.issue_offset), 32'd4);
        chk("t2_mask1", 32'(bus.issue_mask), 32'hF);
        bus.cmpl_valid = 1'b1;
        tick();
        chk("t2_valid2", 32'(bus.issue_valid), 32'd1);
        chk("t2_off2", 32'(bus.issue_offset), 32'd8);
        chk("t2_mask2", 32'(bus.issue_mask), 32'h3);
        tick();
        chk("t2_drain", 32'(bus.issue_valid), 32'd0);
        tick();
        bus.cmpl_valid = 1'b0;
        tick();
        chk("t2_done", 32'(bus.done), 32'd1);
        tick();
        chk("t2_err", 32'(bus.err), 32'd0);

        // Credit limit, len=16, no completions
        bus.start = 1'b1; bus.len = 16'd16;
        tick();
        bus.start = 1'b0;
        chk("t3_valid0", 32'(bus.issue_valid), 32'd1);
        tick();
        chk("t3_valid1", 32'(bus.issue_valid), 32'd1);
        tick();
        chk("t3_blocked", 32'(bus.issue_valid), 32'd0);
        tick();
        chk("t3_still_blocked", 32'(bus.issue_valid), 32'd0);
        bus.cmpl_valid = 1'b1;
        tick();
        bus.cmpl_valid = 1'b0;
        chk("t3_reissue_valid", 32'(bus.issue_valid), 32'd1);
        chk("t3_reissue_off", 32'(bus.issue_offset), 32'd8);
        chk("t3_reissue_mask", 32'(bus.issue_mask), 32'hF);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();

        // Backpressure on offset 4, len=8
        bus.start = 1'b1; bus.len = 16'd8;
        tick();
        bus.start = 1'b0;
        tick();
        chk("t4_off", 32'(bus.issue_offset), 32'd4);
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_valid", 32'(bus.issue_valid), 32'd1);
            chk("t4_hold_off", 32'(bus.issue_offset), 32'd4);
            chk("t4_hold_mask", 32'(bus.issue_mask), 32'hF);
        end
        chk("t4_perf", bus.perf_stall, PERF_EXP);
        bus.issue_ready = 1'b1;
        tick();
        chk("t4_drain", 32'(bus.issue_valid), 32'd0);
        chk("t4_perf_hold", bus.perf_stall, PERF_EXP);
        bus.cmpl_valid = 1'b1;
        tick();
        tick();
        bus.cmpl_valid = 1'b0;
        tick();
        chk("t4_done", 32'(bus.done), 32'd1);
        tick();

        // Zero length, spurious completion, err sticky/clear
        bus.start = 1'b1; bus.len = 16'd0;
        tick();
        bus.start = 1'b0;
        chk("t5_done", 32'(bus.done), 32'd1);
        chk("t5_noissue", 32'(bus.issue_valid), 32'd0);
        tick();
        chk("t5_idle", 32'(bus.busy), 32'd0);
        bus.cmpl_valid = 1'b1;
        tick();
        bus.cmpl_valid = 1'b0;
        chk("t5_err_set", 32'(bus.err), 32'd1);
        tick();
        chk("t5_err_sticky", 32'(bus.err), 32'd1);
        bus.start = 1'b1; bus.len = 16'd4;
        tick();
        bus.start = 1'b0;
        chk("t5_err_clr", 32'(bus.err), 32'd0);
        chk("t5_off", 32'(bus.issue_offset), 32'd0);
        chk("t5_mask", 32'(bus.issue_mask), 32'hF);
        tick();
        chk("t5_drain", 32'(bus.issue_valid), 32'd0);
        bus.cmpl_valid = 1'b1;
        tick();
        bus.cmpl_valid = 1'b0;
        tick();
        chk("t5_done2", 32'(bus.done), 32'd1);
        tick();

        // Reset mid-job after one issue
        bus.start = 1'b1; bus.len = 16'd12;
        tick();
        bus.start = 1'b0;
        tick();
        chk("t6_pre_off", 32'(bus.issue_offset), 32'd4);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("t6_rst");
        #2 rst_n = 1'b1;
        tick();
        bus.start = 1'b1; bus.len = 16'd4;
        tick();
        bus.start = 1'b0;
        chk("t6_valid", 32'(bus.issue_valid), 32'd1);
        chk("t6_off", 32'(bus.issue_offset), 32'd0);
        chk("t6_mask", 32'(bus.issue_mask), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
